// File: rtl/crc_frame_ctrl_if.sv
// Signal bundle between the two byte sources, the shared bit-serial CRC engine
// and the result consumer. The slave view belongs to crc_frame_ctrl.
interface crc_frame_ctrl_if #(
    parameter int CRC_W = 8
);
    logic             S0_VALID;
    logic [7:0]       S0_DATA;
    logic             S0_LAST;
    logic             S0_READY;
    logic             S1_VALID;
    logic [7:0]       S1_DATA;
    logic             S1_LAST;
    logic             S1_READY;
    logic             CRC_DATA;
    logic             CRC_ACTIVE;
    logic             CRC_RST_N;
    logic             CRC_BIT;
    logic             OUT_VALID;
    logic [CRC_W-1:0] OUT_CRC;
    logic             OUT_ID;
    logic             OUT_ERR;
    logic             BUSY;

    modport slave (
        input  S0_VALID, S0_DATA, S0_LAST,
        output S0_READY,
        input  S1_VALID, S1_DATA, S1_LAST,
        output S1_READY,
        output CRC_DATA, CRC_ACTIVE, CRC_RST_N,
        input  CRC_BIT,
        output OUT_VALID, OUT_CRC, OUT_ID, OUT_ERR, BUSY
    );

    modport master (
        output S0_VALID, S0_DATA, S0_LAST,
        input  S0_READY,
        output S1_VALID, S1_DATA, S1_LAST,
        input  S1_READY,
        input  CRC_DATA, CRC_ACTIVE, CRC_RST_N,
        output CRC_BIT,
        input  OUT_VALID, OUT_CRC, OUT_ID, OUT_ERR, BUSY
    );
endinterface

// File: rtl/crc_frame_ctrl.sv
// Round-robin sequencer sharing one bit-serial CRC engine between two byte sources:
// serializes each frame LSB-first, collects the serial CRC and reports it with a pulse.
module crc_frame_ctrl #(
    parameter int SAMPLE_DLY = 2,
    parameter int CRC_W      = 8
) (
    input logic              CLK,
    input logic              RST,
    crc_frame_ctrl_if.slave  bus
);
    localparam int              DW     = $clog2(CRC_W + SAMPLE_DLY);
    localparam logic [DW-1:0]   D_LAST = DW'(CRC_W + SAMPLE_DLY - 1);
    localparam logic [DW-1:0]   D_SMP  = DW'(SAMPLE_DLY);

    typedef enum logic [2:0] {IDLE, SHIFT, DRAIN, DONE, FLUSH, ABORT} state_t;

    state_t           state, state_n;
    logic [7:0]       shreg, shreg_n;
    logic [2:0]       bcnt, bcnt_n;
    logic [7:0]       hold, hold_n;
    logic             hold_v, hold_v_n;
    logic             hold_last, hold_last_n;
    logic             last_cur, last_cur_n;
    logic             last_acc, last_acc_n;
    logic             grant, grant_n;
    logic             ptr, ptr_n;
    logic [DW-1:0]    dcnt, dcnt_n;
    logic [CRC_W-1:0] acc, acc_n;

    logic             crc_data_q, crc_active_q, crc_rst_n_q;
    logic             out_valid_q, out_id_q, out_err_q;
    logic [CRC_W-1:0] out_crc_q;

    logic             sel_valid, sel_last, win, rdy, take, rdy0, rdy1, res_n;
    logic [7:0]       sel_data;

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bcnt_n      = bcnt;
        hold_n      = hold;
        hold_v_n    = hold_v;
        hold_last_n = hold_last;
        last_cur_n  = last_cur;
        last_acc_n  = last_acc;
        grant_n     = grant;
        ptr_n       = ptr;
        dcnt_n      = dcnt;
        acc_n       = acc;
        rdy0        = 1'b0;
        rdy1        = 1'b0;
        rdy         = 1'b0;
        take        = 1'b0;
        win         = 1'b0;
        sel_valid   = grant ? bus.S1_VALID : bus.S0_VALID;
        sel_data    = grant ? bus.S1_DATA  : bus.S0_DATA;
        sel_last    = grant ? bus.S1_LAST  : bus.S0_LAST;

        case (state)
            IDLE: begin
                if (bus.S0_VALID || bus.S1_VALID) begin
                    win        = bus.S1_VALID && (!bus.S0_VALID || ptr);
                    grant_n    = win;
                    ptr_n      = !win;
                    rdy0       = !win;
                    rdy1       = win;
                    shreg_n    = win ? bus.S1_DATA : bus.S0_DATA;
                    last_cur_n = win ? bus.S1_LAST : bus.S0_LAST;
                    last_acc_n = win ? bus.S1_LAST : bus.S0_LAST;
                    hold_v_n   = 1'b0;
                    bcnt_n     = '0;
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                rdy    = !hold_v && !last_acc;
                take   = rdy && sel_valid;
                rdy0   = rdy && !grant;
                rdy1   = rdy && grant;
                bcnt_n = bcnt + 3'd1;
                if (take)
                    last_acc_n = sel_last;
                // A byte offered on the final bit bypasses the holding register straight into shreg.
                if (bcnt == 3'd7) begin
                    if (last_cur) begin
                        state_n = DRAIN;
                        dcnt_n  = '0;
                    end else if (hold_v || take) begin
                        shreg_n    = hold_v ? hold : sel_data;
                        last_cur_n = hold_v ? hold_last : sel_last;
                        hold_v_n   = 1'b0;
                    end else begin
                        state_n = FLUSH;
                    end
                end else if (take) begin
                    hold_n      = sel_data;
                    hold_v_n    = 1'b1;
                    hold_last_n = sel_last;
                end
            end
            DRAIN: begin
                dcnt_n = dcnt + DW'(1);
                if (dcnt >= D_SMP)
                    acc_n = {bus.CRC_BIT, acc[CRC_W-1:1]};
                if (dcnt == D_LAST)
                    state_n = DONE;
            end
            DONE: state_n = IDLE;
            FLUSH: begin
                rdy0 = !grant;
                rdy1 = grant;
                if (sel_valid && sel_last)
                    state_n = ABORT;
            end
            ABORT: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        res_n = (state_n == DONE) || (state_n == ABORT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            shreg        <= '0;
            bcnt         <= '0;
            hold         <= '0;
            hold_v       <= 1'b0;
            hold_last    <= 1'b0;
            last_cur     <= 1'b0;
            last_acc     <= 1'b0;
            grant        <= 1'b0;
            ptr          <= 1'b0;
            dcnt         <= '0;
            acc          <= '0;
            crc_data_q   <= 1'b0;
            crc_active_q <= 1'b0;
            crc_rst_n_q  <= 1'b1;
            out_valid_q  <= 1'b0;
            out_id_q     <= 1'b0;
            out_err_q    <= 1'b0;
            out_crc_q    <= '0;
        end else begin
            state        <= state_n;
            shreg        <= shreg_n;
            bcnt         <= bcnt_n;
            hold         <= hold_n;
            hold_v       <= hold_v_n;
            hold_last    <= hold_last_n;
            last_cur     <= last_cur_n;
            last_acc     <= last_acc_n;
            grant        <= grant_n;
            ptr          <= ptr_n;
            dcnt         <= dcnt_n;
            acc          <= acc_n;
            crc_active_q <= (state_n == SHIFT);
            crc_data_q   <= (state_n == SHIFT) ? shreg_n[bcnt_n] : 1'b0;
            crc_rst_n_q  <= !res_n;
            out_valid_q  <= res_n;
            if (res_n) begin
                out_id_q  <= grant_n;
                out_err_q <= (state_n == ABORT);
                out_crc_q <= (state_n == ABORT) ? '0 : acc_n;
            end
        end
    end

    assign bus.S0_READY   = rdy0;
    assign bus.S1_READY   = rdy1;
    assign bus.CRC_DATA   = crc_data_q;
    assign bus.CRC_ACTIVE = crc_active_q;
    assign bus.CRC_RST_N  = crc_rst_n_q;
    assign bus.OUT_VALID  = out_valid_q;
    assign bus.OUT_CRC    = out_crc_q;
    assign bus.OUT_ID     = out_id_q;
    assign bus.OUT_ERR    = out_err_q;
    assign bus.BUSY       = (state != IDLE);
endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed bench for crc_frame_ctrl: a stub serial CRC engine, a frame-level expectation
// model (bit stream, active-run lengths, results) and one per-cycle compare process.
module tb_crc_frame_ctrl;
    localparam logic [7:0] SEED = 8'hFF;
    localparam logic [7:0] POLY = 8'h07;

    typedef struct {
        int         id;
        bit         err;
        logic [7:0] crc;
    } res_t;

    logic CLK;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    crc_frame_ctrl_if #(.CRC_W(8)) bus();

    crc_frame_ctrl #(.SAMPLE_DLY(2), .CRC_W(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    bit   exp_bits[$];
    int   exp_runs[$];
    res_t exp_res[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CRC of a whole frame: bytes in order, each byte LSB-first.
    function automatic logic [7:0] golden(input logic [7:0] b[$]);
        logic [7:0] c;
        c = SEED;
        foreach (b[i])
            for (int k = 0; k < 8; k++)
                c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i][k]) ? POLY : 8'h00);
        return c;
    endfunction

    // Stand-in for the external engine: CRC bit k appears 2+k cycles after ACTIVE falls.
    logic [7:0] eng_crc;
    int         eng_idle;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            eng_crc  <= SEED;
            eng_idle <= 100;
        end else begin
            if (!bus.CRC_RST_N)
                eng_crc <= SEED;
            else if (bus.CRC_ACTIVE)
                eng_crc <= {eng_crc[6:0], 1'b0} ^ ((eng_crc[7] ^ bus.CRC_DATA) ? POLY : 8'h00);
            eng_idle <= bus.CRC_ACTIVE ? 0 : ((eng_idle < 100) ? eng_idle + 1 : eng_idle);
        end
    end
    always_comb bus.CRC_BIT = (eng_idle >= 2 && eng_idle < 10) ? eng_crc[3'(eng_idle - 2)] : 1'b0;

    // Per-cycle comparison against the frame-level expectations.
    int         run;
    int         since;
    logic [7:0] last_crc;
    logic       last_id, last_err;
    always @(negedge CLK) begin
        if (!RST) begin
            run      = 0;
            since    = 100;
            last_crc = 8'h00;
            last_id  = 1'b0;
            last_err = 1'b0;
        end else begin
            if (bus.CRC_ACTIVE) begin
                run++;
                since = 0;
                if (exp_bits.size() == 0) check("extra_active_bit", 1, 0);
                else check("crc_data", bus.CRC_DATA, exp_bits.pop_front());
            end else begin
                if (run > 0) begin
                    if (exp_runs.size() == 0) check("extra_active_run", run, 0);
                    else check("active_run_len", run, exp_runs.pop_front());
                    run = 0;
                end
                since++;
            end
            check("crc_rst_n_vs_valid", bus.CRC_RST_N, !bus.OUT_VALID);
            if (bus.CRC_ACTIVE || bus.OUT_VALID) check("busy", bus.BUSY, 1);
            if (bus.OUT_VALID) begin
                if (exp_res.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    res_t r;
                    r = exp_res.pop_front();
                    check("out_id", bus.OUT_ID, r.id);
                    check("out_err", bus.OUT_ERR, r.err);
                    check("out_crc", bus.OUT_CRC, r.crc);
                    if (!r.err) check("result_latency", since, 11);
                end
                last_crc = bus.OUT_CRC;
                last_id  = bus.OUT_ID;
                last_err = bus.OUT_ERR;
            end else begin
                check("hold_crc", bus.OUT_CRC, last_crc);
                check("hold_id", bus.OUT_ID, last_id);
                check("hold_err", bus.OUT_ERR, last_err);
            end
        end
    end

    task automatic drive(input int src, input logic v, input logic [7:0] d, input logic l);
        if (src == 0) begin
            bus.S0_VALID = v; bus.S0_DATA = d; bus.S0_LAST = l;
        end else begin
            bus.S1_VALID = v; bus.S1_DATA = d; bus.S1_LAST = l;
        end
    endtask

    task automatic drop(input int src);
        if (src == 0) bus.S0_VALID = 1'b0;
        else          bus.S1_VALID = 1'b0;
    endtask

    // Called just after a negedge with the byte already driven; returns at a negedge.
    task automatic send_byte(input int src, output bit ok);
        logic r;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            r = (src == 0) ? bus.S0_READY : bus.S1_READY;
            @(posedge CLK);
            @(negedge CLK);
            if (r) begin
                ok = 1'b1;
                return;
            end
        end
        check("ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input int src, input logic [7:0] b[$], input int gap_after, input int gap_len);
        bit ok;
        foreach (b[i]) begin
            drive(src, 1'b1, b[i], (i == b.size() - 1));
            send_byte(src, ok);
            if (!ok) break;
            if (i == gap_after) begin
                drop(src);
                repeat (gap_len) @(negedge CLK);
            end
        end
        drop(src);
    endtask

    // sent < 0: frame completes normally; otherwise it underruns after 'sent' bytes.
    task automatic expect_frame(input int id, input logic [7:0] b[$], input int sent);
        res_t r;
        int   n;
        n = (sent < 0) ? b.size() : sent;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 8; k++)
                exp_bits.push_back(b[i][k]);
        exp_runs.push_back(8 * n);
        r.id  = id;
        r.err = (sent >= 0);
        r.crc = (sent < 0) ? golden(b) : 8'h00;
        exp_res.push_back(r);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (exp_res.size() == 0 && !bus.BUSY) begin
                @(negedge CLK);
                return;
            end
        end
        check("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f0[$];
        logic [7:0] f1[$];
        logic [7:0] q[$];

        RST = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge CLK);
        check("reset_busy", bus.BUSY, 0);
        check("reset_crc_rst_n", bus.CRC_RST_N, 1);
        check("reset_out_valid", bus.OUT_VALID, 0);
        #2 RST = 1'b1;
        @(negedge CLK);

        // Literal pins on the reference model.
        q = '{8'h00};
        check("golden_00", golden(q), 8'hF3);
        q = '{8'h01};
        check("golden_01", golden(q), 8'h7A);

        // One-byte frame from S0.
        q = '{8'h00};
        expect_frame(0, q, -1);
        send_frame(0, q, -1, 0);
        wait_idle();
        check("t1_crc_literal", bus.OUT_CRC, 8'hF3);

        // Four-byte back-to-back frame from S1.
        q = '{8'h12, 8'h34, 8'h56, 8'h78};
        expect_frame(1, q, -1);
        send_frame(1, q, -1, 0);
        wait_idle();

        // Underrun after the first byte, then a clean frame from a fresh seed.
        q = '{8'hA1, 8'hB2, 8'hC3};
        expect_frame(0, q, 1);
        send_frame(0, q, 0, 20);
        wait_idle();
        check("abort_err_held", bus.OUT_ERR, 1);
        q = '{8'h9E, 8'h47};
        expect_frame(0, q, -1);
        send_frame(0, q, -1, 0);
        wait_idle();

        // Reset in the middle of shifting a 2-byte frame.
        q = '{8'h5A};
        for (int k = 0; k < 8; k++) exp_bits.push_back(q[0][k]);
        drive(0, 1'b1, 8'h5A, 1'b0);
        #1 check("rst_t_ready_idle", bus.S0_READY, 1);
        @(negedge CLK);
        drive(0, 1'b1, 8'h6B, 1'b1);
        #1 check("rst_t_ready_hold", bus.S0_READY, 1);
        @(negedge CLK);
        drop(0);
        @(posedge CLK);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("midrst_active", bus.CRC_ACTIVE, 0);
        check("midrst_data", bus.CRC_DATA, 0);
        check("midrst_rst_n", bus.CRC_RST_N, 1);
        check("midrst_valid", bus.OUT_VALID, 0);
        check("midrst_crc", bus.OUT_CRC, 8'h00);
        check("midrst_id", bus.OUT_ID, 0);
        check("midrst_err", bus.OUT_ERR, 0);
        check("midrst_busy", bus.BUSY, 0);
        exp_bits.delete();
        exp_runs.delete();
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);
        q = '{8'h5A, 8'h6B};
        expect_frame(0, q, -1);
        send_frame(0, q, -1, 0);
        wait_idle();

        // Two identical frames must give identical CRCs.
        for (int n = 0; n < 2; n++) begin
            q = '{8'h01};
            expect_frame(0, q, -1);
            send_frame(0, q, -1, 0);
            wait_idle();
            check("reseed_crc_literal", bus.OUT_CRC, 8'h7A);
        end

        // Clean reset restores the pointer; simultaneous requests alternate S0, S1, S0, S1.
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);
        f0 = '{8'hC3};
        f1 = '{8'h3C, 8'hE7};
        for (int n = 0; n < 2; n++) begin
            expect_frame(0, f0, -1);
            expect_frame(1, f1, -1);
            fork
                send_frame(0, f0, -1, 0);
                send_frame(1, f1, -1, 0);
            join
            wait_idle();
            check("arb_last_id", bus.OUT_ID, 1);
        end

        check("leftover_bits", exp_bits.size(), 0);
        check("leftover_runs", exp_runs.size(), 0);
        check("leftover_results", exp_res.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
